// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Holds the FSM state enum, Funct3 access codes and the WAIT_R timeout default.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 255;

  function automatic logic f3_legal(
    input logic [2:0] f3,
    input logic       wr
  );
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (!wr && ((f3 == F3_BU) || (f3 == F3_HU)));
  endfunction

  function automatic logic [3:0] byte_en(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    unique case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_rep(
    input logic [2:0]  f3,
    input logic [31:0] sd
  );
    unique case (f3[1:0])
      2'b00:   return {4{sd[7:0]}};
      2'b01:   return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Memory bus between the load/store unit (master) and memory (slave).
// Request: BusValid/BusReady, BusWrite, BusAddr, BusWData, BusByteEn; response: BusRData/BusRValid.
interface lsu_if;
  logic        BusValid;
  logic        BusReady;
  logic        BusWrite;
  logic [31:0] BusAddr;
  logic [31:0] BusWData;
  logic [3:0]  BusByteEn;
  logic [31:0] BusRData;
  logic        BusRValid;

  modport master (
    output BusValid, BusWrite, BusAddr, BusWData, BusByteEn,
    input  BusReady, BusRData, BusRValid
  );

  modport slave (
    input  BusValid, BusWrite, BusAddr, BusWData, BusByteEn,
    output BusReady, BusRData, BusRValid
  );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load lane select and sign/zero extension.
// Ports: i_rdata (bus word), i_a (byte offset), i_funct3 (access type), o_data (extended result).
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_a,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  always_comb begin
    w_b    = 8'(i_rdata >> {i_a, 3'b000});
    w_h    = i_a[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_data = i_rdata;
    unique case (1'b1)
      (i_funct3 == F3_B):  o_data = {{24{w_b[7]}}, w_b};
      (i_funct3 == F3_H):  o_data = {{16{w_h[15]}}, w_h};
      (i_funct3 == F3_BU): o_data = {24'h0, w_b};
      (i_funct3 == F3_HU): o_data = {16'h0, w_h};
      default:             o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one bus access per MemReq through IDLE/REQ/WAIT_R/DONE.
// Ports: clk, rst_n, MemReq/MemWrite/Funct3/Address/StoreData in; MemoryData/Stall/AccessFault out; bus (lsu_if.master).
// Option: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Address,
  input  logic [31:0] StoreData,
  output logic [31:0] MemoryData,
  output logic        Stall,
  output logic        AccessFault,
  lsu_if.master       bus
);

  lsu_state_e  r_state;
  lsu_state_e  w_next;
  logic [7:0]  r_cnt;
  logic [2:0]  r_f3;
  logic [1:0]  r_a;
  logic        r_valid;
  logic        r_write;
  logic [31:0] r_baddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_mdata;
  logic        r_fault;
  logic        w_mis;
  logic        w_legal;
  logic        w_tmo;
  logic [31:0] w_addr;
  logic [31:0] w_load;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis  = ((Funct3[1:0] == 2'b01) && Address[0]) ||
                  ((Funct3[1:0] == 2'b10) && (Address[1:0] != 2'b00));
  assign w_addr = Address;
`else
  assign w_mis = 1'b0;
  always_comb begin
    w_addr = Address;
    if (Funct3[1:0] == 2'b01)
      w_addr[0] = 1'b0;
    else if (Funct3[1:0] == 2'b10)
      w_addr[1:0] = 2'b00;
  end
`endif

  assign w_legal = f3_legal(Funct3, MemWrite) && !w_mis;
  assign w_tmo   = (r_cnt == 8'(TIMEOUT_CYCLES - 1));

  lsu_load_align u_align (
    .i_rdata  (bus.BusRData),
    .i_a      (r_a),
    .i_funct3 (r_f3),
    .o_data   (w_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (MemReq) w_next = w_legal ? REQ : DONE;
      REQ:    if (bus.BusReady) w_next = r_write ? DONE : WAIT_R;
      WAIT_R: if (bus.BusRValid || w_tmo) w_next = DONE;
      DONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_f3    <= '0;
      r_a     <= '0;
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_baddr <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_mdata <= '0;
      r_fault <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      r_cnt   <= (r_state == WAIT_R) ? r_cnt + 8'd1 : 8'd0;
      unique case (r_state)
        IDLE: begin
          if (MemReq && w_legal) begin
            r_f3    <= Funct3;
            r_a     <= w_addr[1:0];
            r_valid <= 1'b1;
            r_write <= MemWrite;
            r_baddr <= {w_addr[31:2], 2'b00};
            r_wdata <= wdata_rep(Funct3, StoreData);
            r_be    <= byte_en(Funct3, w_addr[1:0]);
          end else if (MemReq) begin
            r_fault <= 1'b1;
            r_mdata <= '0;
          end
        end
        REQ: begin
          if (bus.BusReady) begin
            r_valid <= 1'b0;
            r_write <= 1'b0;
          end
        end
        WAIT_R: begin
          if (bus.BusRValid) begin
            r_mdata <= w_load;
          end else if (w_tmo) begin
            r_mdata <= '0;
            r_fault <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Stall         = MemReq && (r_state != DONE);
  assign MemoryData    = r_mdata;
  assign AccessFault   = r_fault;
  assign bus.BusValid  = r_valid;
  assign bus.BusWrite  = r_write;
  assign bus.BusAddr   = r_baddr;
  assign bus.BusWData  = r_wdata;
  assign bus.BusByteEn = r_be;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with immediate-assertion checks.
// Drives the bus slave side directly; TIMEOUT_CYCLES is set to 4.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        MemReq;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Address;
  logic [31:0] StoreData;
  logic [31:0] MemoryData;
  logic        Stall;
  logic        AccessFault;

  int n_tests;
  int n_fail;

  lsu_if bus_if ();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .MemReq      (MemReq),
    .MemWrite    (MemWrite),
    .Funct3      (Funct3),
    .Address     (Address),
    .StoreData   (StoreData),
    .MemoryData  (MemoryData),
    .Stall       (Stall),
    .AccessFault (AccessFault),
    .bus         (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] sd);
    MemReq    = 1'b1;
    MemWrite  = wr;
    Funct3    = f3;
    Address   = a;
    StoreData = sd;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    MemReq = 1'b0;
    MemWrite = 1'b0;
    Funct3 = 3'b000;
    Address = '0;
    StoreData = '0;
    bus_if.BusReady = 1'b0;
    bus_if.BusRValid = 1'b0;
    bus_if.BusRData = '0;

    #12;
    chk1("rst_valid", bus_if.BusValid, 1'b0);
    chk1("rst_write", bus_if.BusWrite, 1'b0);
    chk("rst_be", 32'(bus_if.BusByteEn), 32'h0);
    chk("rst_addr", bus_if.BusAddr, 32'h0);
    chk("rst_wdata", bus_if.BusWData, 32'h0);
    chk("rst_mdata", MemoryData, 32'h0);
    chk1("rst_fault", AccessFault, 1'b0);
    chk1("rst_stall", Stall, 1'b0);
    rst_n = 1'b1;
    step();

    // LB A=0x103, data after two wait cycles
    req(1'b0, 3'b000, 32'h103, 32'h0);
    step();
    chk1("lb_valid", bus_if.BusValid, 1'b1);
    chk("lb_be", 32'(bus_if.BusByteEn), 32'h8);
    chk("lb_addr", bus_if.BusAddr, 32'h100);
    chk1("lb_stall_req", Stall, 1'b1);
    bus_if.BusReady = 1'b1;
    step();
    bus_if.BusReady = 1'b0;
    chk1("lb_valid_drop", bus_if.BusValid, 1'b0);
    chk1("lb_stall_w0", Stall, 1'b1);
    step();
    chk1("lb_stall_w1", Stall, 1'b1);
    step();
    bus_if.BusRValid = 1'b1;
    bus_if.BusRData = 32'h8000_0000;
    step();
    chk("lb_mdata", MemoryData, 32'hFFFF_FF80);
    chk1("lb_stall_done", Stall, 1'b0);
    chk1("lb_fault", AccessFault, 1'b0);
    bus_if.BusRValid = 1'b0;
    bus_if.BusRData = '0;
    MemReq = 1'b0;
    step();
    chk("lb_hold", MemoryData, 32'hFFFF_FF80);

    // SH A=0x202, ready low for three REQ cycles
    req(1'b1, 3'b001, 32'h202, 32'hDEAD_1234);
    step();
    chk1("sh_write", bus_if.BusWrite, 1'b1);
    chk("sh_addr", bus_if.BusAddr, 32'h200);
    for (int i = 0; i < 3; i++) begin
      chk1("sh_valid", bus_if.BusValid, 1'b1);
      chk("sh_wdata", bus_if.BusWData, 32'h1234_1234);
      chk("sh_be", 32'(bus_if.BusByteEn), 32'hC);
      step();
    end
    chk1("sh_valid4", bus_if.BusValid, 1'b1);
    bus_if.BusReady = 1'b1;
    step();
    bus_if.BusReady = 1'b0;
    chk1("sh_done_fault", AccessFault, 1'b0);
    chk1("sh_done_stall", Stall, 1'b0);
    chk("sh_mdata_held", MemoryData, 32'hFFFF_FF80);
    MemReq = 1'b0;
    step();

    // LW timeout, with a stray BusRValid during REQ
    req(1'b0, 3'b010, 32'h300, 32'h0);
    step();
    bus_if.BusRValid = 1'b1;
    step();
    chk1("tmo_stray_rvalid", bus_if.BusValid, 1'b1);
    bus_if.BusRValid = 1'b0;
    bus_if.BusReady = 1'b1;
    step();
    bus_if.BusReady = 1'b0;
    step();
    step();
    step();
    chk1("tmo_stall_w3", Stall, 1'b1);
    chk1("tmo_fault_w3", AccessFault, 1'b0);
    step();
    chk1("tmo_fault", AccessFault, 1'b1);
    chk("tmo_mdata", MemoryData, 32'h0);
    chk1("tmo_stall", Stall, 1'b0);
    MemReq = 1'b0;
    step();
    chk1("tmo_fault_pulse", AccessFault, 1'b0);

    // LW A=0x101 misaligned
    req(1'b0, 3'b010, 32'h101, 32'h0);
    step();
`ifdef LSU_MISALIGN_TRAP_EN
    chk1("mis_valid", bus_if.BusValid, 1'b0);
    chk1("mis_fault", AccessFault, 1'b1);
    chk("mis_mdata", MemoryData, 32'h0);
    MemReq = 1'b0;
    step();
    chk1("mis_valid_idle", bus_if.BusValid, 1'b0);
`else
    chk1("mis_valid", bus_if.BusValid, 1'b1);
    chk("mis_addr", bus_if.BusAddr, 32'h100);
    chk("mis_be", 32'(bus_if.BusByteEn), 32'hF);
    bus_if.BusReady = 1'b1;
    step();
    bus_if.BusReady = 1'b0;
    bus_if.BusRValid = 1'b1;
    bus_if.BusRData = 32'h1122_3344;
    step();
    chk("mis_mdata", MemoryData, 32'h1122_3344);
    chk1("mis_fault", AccessFault, 1'b0);
    bus_if.BusRValid = 1'b0;
    MemReq = 1'b0;
    step();
`endif

    // LHU A=0x2 then an immediate SB
    req(1'b0, 3'b101, 32'h2, 32'h0);
    step();
    chk("lhu_be", 32'(bus_if.BusByteEn), 32'hC);
    bus_if.BusReady = 1'b1;
    step();
    bus_if.BusReady = 1'b0;
    bus_if.BusRValid = 1'b1;
    bus_if.BusRData = 32'hBEEF_0000;
    step();
    chk("lhu_mdata", MemoryData, 32'h0000_BEEF);
    bus_if.BusRValid = 1'b0;
    req(1'b1, 3'b000, 32'h5, 32'h0000_00A5);
    step();
    chk1("sb_idle_valid", bus_if.BusValid, 1'b0);
    chk1("sb_idle_stall", Stall, 1'b1);
    step();
    chk1("sb_valid", bus_if.BusValid, 1'b1);
    chk("sb_be", 32'(bus_if.BusByteEn), 32'h2);
    chk("sb_wdata", bus_if.BusWData, 32'hA5A5_A5A5);
    bus_if.BusReady = 1'b1;
    step();
    bus_if.BusReady = 1'b0;
    chk("sb_mdata_held", MemoryData, 32'h0000_BEEF);
    chk1("sb_fault", AccessFault, 1'b0);
    MemReq = 1'b0;
    step();

    // Reset in WAIT_R, then a late BusRValid
    req(1'b0, 3'b010, 32'h400, 32'h0);
    step();
    bus_if.BusReady = 1'b1;
    step();
    bus_if.BusReady = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rw_mdata", MemoryData, 32'h0);
    chk("rw_be", 32'(bus_if.BusByteEn), 32'h0);
    chk("rw_addr", bus_if.BusAddr, 32'h0);
    MemReq = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    bus_if.BusRValid = 1'b1;
    bus_if.BusRData = 32'hCAFE_F00D;
    step();
    step();
    chk("late_mdata", MemoryData, 32'h0);
    chk1("late_valid", bus_if.BusValid, 1'b0);
    chk1("late_fault", AccessFault, 1'b0);
    bus_if.BusRValid = 1'b0;

    // Reset while BusValid is high
    req(1'b0, 3'b010, 32'h500, 32'h0);
    step();
    chk1("rq_valid_pre", bus_if.BusValid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rq_valid_rst", bus_if.BusValid, 1'b0);
    MemReq = 1'b0;
    #2;
    rst_n = 1'b1;
    step();

    // LBU A=0x1 after reset recovery
    req(1'b0, 3'b100, 32'h1, 32'h0);
    step();
    chk("lbu_be", 32'(bus_if.BusByteEn), 32'h2);
    bus_if.BusReady = 1'b1;
    step();
    bus_if.BusReady = 1'b0;
    bus_if.BusRValid = 1'b1;
    bus_if.BusRData = 32'h0000_8000;
    step();
    chk("lbu_mdata", MemoryData, 32'h0000_0080);
    bus_if.BusRValid = 1'b0;
    MemReq = 1'b0;
    step();

    // Illegal store Funct3=100
    req(1'b1, 3'b100, 32'h10, 32'h0);
    step();
    chk1("ill_st_fault", AccessFault, 1'b1);
    chk1("ill_st_valid", bus_if.BusValid, 1'b0);
    chk("ill_st_mdata", MemoryData, 32'h0);
    chk1("ill_st_stall", Stall, 1'b0);
    MemReq = 1'b0;
    step();
    chk1("ill_st_pulse", AccessFault, 1'b0);

    // Illegal load Funct3=011
    req(1'b0, 3'b011, 32'h20, 32'h0);
    step();
    chk1("ill_ld_fault", AccessFault, 1'b1);
    chk1("ill_ld_valid", bus_if.BusValid, 1'b0);
    MemReq = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles to wait in WAIT_R for read data (range 1..255).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 MemReq  in  1  the current instruction is a load or store; held until Stall drops.
REQ-005 MemWrite  in  1  1 = store, 0 = load; qualified by MemReq.
REQ-006 Funct3  in  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 Address  in  32  byte address (ALUResult).
REQ-008 StoreData  in  32  rs2 value; the low bits are used for SB/SH.
REQ-009 MemoryData  out  32  extended load result, feeding the write-back select stage.
REQ-010 Stall  out  1  freezes PC and register write while the access is in flight.
REQ-011 AccessFault  out  1  one-cycle pulse in DONE marking a misaligned, illegal or timed-out access.
REQ-012 BusValid/BusReady  out/in  1/1  request handshake.
REQ-013 BusWrite  out  1; BusAddr  out  32, word-aligned; BusWData  out  32, lane-replicated; BusByteEn  out  4.
REQ-014 BusRData  in  32; BusRValid  in  1  read response.

Function
REQ-015 The FSM SHALL have the states IDLE, REQ, WAIT_R and DONE.
REQ-016 Stall SHALL equal MemReq && (state != DONE), evaluated combinationally.
REQ-017 In IDLE with MemReq=1 and a legal access, the FSM SHALL latch Address, StoreData, Funct3 and MemWrite, then go to REQ.
REQ-018 In REQ, BusValid SHALL be 1, with BusAddr/BusWData/BusByteEn/BusWrite stable from the latched values until BusReady=1 is sampled.
REQ-019 On acceptance, the FSM SHALL go from REQ to DONE for a store and from REQ to WAIT_R for a load; BusRValid in REQ SHALL be ignored.
REQ-020 In WAIT_R with BusRValid=1, the block SHALL capture the selected lanes and extend them into a MemoryData register, then go to DONE.
REQ-021 A WAIT_R counter SHALL start at 0 on entry; when it reaches TIMEOUT_CYCLES without BusRValid, MemoryData SHALL be set to 0, AccessFault SHALL be set to 1, and the FSM SHALL go to DONE.
REQ-022 DONE SHALL last exactly one cycle, with Stall=0 and MemoryData held, then return to IDLE.
REQ-023 The first cycle of any accepted request SHALL be IDLE, so back-to-back accesses cost 1 idle cycle plus bus latency.
REQ-024 Byte enables SHALL be 0001<<A[1:0] for bytes, 0011<<A[1:0] for halfwords and 1111 for words.
REQ-025 BusWData SHALL replicate the byte into all 4 lanes, or the halfword into both halves.
REQ-026 Load extension SHALL be: LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through; lanes are selected by A[1:0].
REQ-027 Illegal Funct3 (011, 110, 111, or 1xx on a store) SHALL cause no bus transaction; the FSM SHALL go IDLE->DONE with AccessFault=1 and MemoryData=0.
REQ-028 MemoryData SHALL hold its last value outside DONE.

Reset
REQ-029 rst_n=0 SHALL force, immediately: state IDLE, BusValid=0, BusWrite=0, BusByteEn=0, BusAddr=0, BusWData=0, MemoryData=0, AccessFault=0, counter=0.
REQ-030 A reset during REQ or WAIT_R SHALL abandon the access, and any later BusRValid SHALL be ignored until a new request is in WAIT_R.

Configuration
REQ-031 Macro LSU_MISALIGN_TRAP_EN: when defined, a halfword with A[0]=1 or a word with A[1:0]!=0 SHALL be handled as REQ-027 (no bus, fault in DONE).
REQ-032 When LSU_MISALIGN_TRAP_EN is not defined, the address SHALL be forced to natural alignment (A[0] cleared for halfwords, A[1:0] cleared for words) and the access SHALL proceed normally.

Structure
REQ-033 Package lsu_pkg SHALL hold the FSM state enum, the Funct3 access-type localparams and the TIMEOUT_CYCLES default.
REQ-034 Sub-module lsu_load_align SHALL be combinational: lane select plus sign/zero extension from BusRData, A[1:0] and Funct3.

Verification
REQ-035 LB A=0x103 with BusRData=0x80_00_00_00 after 2 wait cycles -> BusByteEn=1000, MemoryData=0xFFFFFF80, Stall high until DONE.
REQ-036 SH A=0x202, StoreData=0x1234 with BusReady held low 3 cycles -> BusValid and BusWData=0x12341234 stable, BusByteEn=1100, DONE with no fault.
REQ-037 LW with no BusRValid and TIMEOUT_CYCLES=4 -> DONE after 4 WAIT_R cycles, AccessFault=1, MemoryData=0.
REQ-038 LW A=0x101: with LSU_MISALIGN_TRAP_EN -> BusValid never asserted, AccessFault=1; without it -> BusAddr=0x100, normal load.
REQ-039 rst_n pulsed low in WAIT_R, then late BusRValid -> BusValid=0 at once, state IDLE, MemoryData stays 0.
REQ-040 LHU A=0x2 with BusRData=0xBEEF0000, then an immediate SB -> MemoryData=0x0000BEEF, one IDLE cycle, then a new BusValid.
